// File: rtl/cle_pkg.sv
// Shared constants, FSM state encoding and label-table entry layout for cle_stats.
package cle_pkg;

  localparam int unsigned IMG_W  = 32;
  localparam int unsigned IMG_H  = 32;
  localparam int unsigned PIX    = IMG_W * IMG_H;
  localparam int unsigned AW     = 10;
  localparam int unsigned LW     = 8;
  localparam int unsigned AREA_W = 11;
  localparam int unsigned CRD_W  = 5;
  localparam int unsigned SUM_W  = 15;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SCAN,
    EMIT,
    DONE
  } state_e;

  typedef struct packed {
    logic [AREA_W-1:0] area;
    logic [CRD_W-1:0]  xmin;
    logic [CRD_W-1:0]  xmax;
    logic [CRD_W-1:0]  ymin;
    logic [CRD_W-1:0]  ymax;
    logic [SUM_W-1:0]  sum_x;
    logic [SUM_W-1:0]  sum_y;
  } entry_t;

  // Empty entry: inverted box so the first pixel sets both min and max.
  function automatic entry_t entry_clr();
    entry_t e;
    e       = '0;
    e.xmin  = CRD_W'(IMG_W - 1);
    e.ymin  = CRD_W'(IMG_H - 1);
    return e;
  endfunction

endpackage

// File: rtl/cle_stats_entry.sv
// One label's accumulator: area, bounding box and (optionally) coordinate sums.
// Ports: clk, reset (async, active-high), clr (load empty entry), upd (add pixel
// at row/col), ent (current entry contents).
// Sums are only accumulated when CLE_STATS_CENTROID_EN is defined; otherwise
// they stay at zero.
module cle_stats_entry
  import cle_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             upd,
  input  logic [CRD_W-1:0] row,
  input  logic [CRD_W-1:0] col,
  output entry_t           ent
);

  entry_t ent_q, ent_d;

  // Update is same-cycle from the flop, so back-to-back pixels of one label chain correctly.
  always_comb begin
    ent_d = ent_q;
    if (clr) begin
      ent_d = entry_clr();
    end else if (upd) begin
      if (ent_q.area != AREA_W'(PIX)) ent_d.area = ent_q.area + AREA_W'(1);
      if (col < ent_q.xmin) ent_d.xmin = col;
      if (col > ent_q.xmax) ent_d.xmax = col;
      if (row < ent_q.ymin) ent_d.ymin = row;
      if (row > ent_q.ymax) ent_d.ymax = row;
`ifdef CLE_STATS_CENTROID_EN
      ent_d.sum_x = ent_q.sum_x + SUM_W'(col);
      ent_d.sum_y = ent_q.sum_y + SUM_W'(row);
`endif
    end
`ifndef CLE_STATS_CENTROID_EN
    ent_d.sum_x = '0;
    ent_d.sum_y = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ent_q <= entry_clr();
    else       ent_q <= ent_d;
  end

  assign ent = ent_q;

endmodule

// File: rtl/cle_stats.sv
// Connected-component statistics: clears a label table, scans the 32x32 label
// map from SRAM, then emits one record per non-empty label on a valid/ready stream.
// Ports: clk, reset (async, active-high), start, sram_a/sram_q (1-cycle read),
// busy, res_* record stream with res_valid/res_ready, ovf (label out of range
// seen this run), done (one-cycle end-of-run pulse).
// Macro CLE_STATS_CENTROID_EN enables the coordinate sum accumulators.
module cle_stats
  import cle_pkg::*;
#(
  parameter int unsigned MAX_LABELS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [AW-1:0]     sram_a,
  input  logic [LW-1:0]     sram_q,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [LW-1:0]     res_label,
  output logic [AREA_W-1:0] res_area,
  output logic [CRD_W-1:0]  res_xmin,
  output logic [CRD_W-1:0]  res_xmax,
  output logic [CRD_W-1:0]  res_ymin,
  output logic [CRD_W-1:0]  res_ymax,
  output logic [SUM_W-1:0]  res_sum_x,
  output logic [SUM_W-1:0]  res_sum_y,
  output logic              ovf,
  output logic              done
);

  localparam int unsigned IW = $clog2(MAX_LABELS + 1);

  state_e          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   daddr_q, daddr_d;
  logic            dval_q, dval_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            res_valid_q, res_valid_d;
  logic [LW-1:0]   res_label_q, res_label_d;
  entry_t          res_q, res_d;
  logic            clr_en, upd_en;
  entry_t          ent [MAX_LABELS];
  entry_t          sel;

  // Label table, entry i holds label i+1.
  for (genvar i = 0; i < MAX_LABELS; i++) begin : g_ent
    cle_stats_entry u_ent (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_en && (idx_q == IW'(i))),
      .upd   (upd_en && (sram_q == LW'(i + 1))),
      .row   (daddr_q[AW-1 -: CRD_W]),
      .col   (daddr_q[CRD_W-1:0]),
      .ent   (ent[i])
    );
  end

  // Entry addressed by the emit index.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < MAX_LABELS; i++) begin
      if (idx_q == IW'(i + 1)) sel = ent[i];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    daddr_d     = cnt_q[AW-1:0];
    dval_d      = (state_q == SCAN) && (cnt_q != (AW+1)'(PIX));
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    res_valid_d = res_valid_q;
    res_label_d = res_label_q;
    res_d       = res_q;
    clr_en      = 1'b0;
    upd_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          idx_d   = '0;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      CLR: begin
        clr_en = 1'b1;
        if (idx_q == IW'(MAX_LABELS - 1)) begin
          state_d = SCAN;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      SCAN: begin
        // dval_q marks sram_q as the data for daddr_q.
        upd_en = dval_q;
        if (dval_q && (sram_q > LW'(MAX_LABELS))) ovf_d = 1'b1;
        if (cnt_q == (AW+1)'(PIX)) begin
          state_d = EMIT;
          idx_d   = IW'(1);
        end else begin
          cnt_d = cnt_q + (AW+1)'(1);
        end
      end
      EMIT: begin
        if (res_valid_q) begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            if (idx_q == IW'(MAX_LABELS)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end else if (sel.area == '0) begin
          if (idx_q == IW'(MAX_LABELS)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          res_valid_d = 1'b1;
          res_d       = sel;
          res_label_d = LW'(idx_q);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      daddr_q     <= '0;
      dval_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_label_q <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      daddr_q     <= daddr_d;
      dval_q      <= dval_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      res_label_q <= res_label_d;
      res_q       <= res_d;
    end
  end

  assign sram_a    = cnt_q[AW-1:0];
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_label = res_label_q;
  assign res_area  = res_q.area;
  assign res_xmin  = res_q.xmin;
  assign res_xmax  = res_q.xmax;
  assign res_ymin  = res_q.ymin;
  assign res_ymax  = res_q.ymax;
  assign res_sum_x = res_q.sum_x;
  assign res_sum_y = res_q.sum_y;

endmodule

// File: tb/tb_cle_stats.sv
// Directed, scoreboard-based bench for cle_stats with a 1-cycle SRAM model.
module tb_cle_stats;
  import cle_pkg::*;

  localparam int ML = 16;

  logic              clk = 1'b0;
  logic              reset, start, res_ready;
  logic [AW-1:0]     sram_a;
  logic [LW-1:0]     sram_q;
  logic              busy, res_valid, ovf, done;
  logic [LW-1:0]     res_label;
  logic [AREA_W-1:0] res_area;
  logic [CRD_W-1:0]  res_xmin, res_xmax, res_ymin, res_ymax;
  logic [SUM_W-1:0]  res_sum_x, res_sum_y;

  logic [LW-1:0] mem [0:PIX-1];

  cle_stats #(.MAX_LABELS(ML)) dut (
    .clk(clk), .reset(reset), .start(start), .sram_a(sram_a), .sram_q(sram_q),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_label(res_label),
    .res_area(res_area), .res_xmin(res_xmin), .res_xmax(res_xmax), .res_ymin(res_ymin),
    .res_ymax(res_ymax), .res_sum_x(res_sum_x), .res_sum_y(res_sum_y), .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) sram_q <= mem[sram_a];

  typedef struct {
    int label; int area; int xmin; int xmax; int ymin; int ymax; int sx; int sy;
  } rec_t;

  rec_t exp_q[$];
  bit   exp_ovf;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < PIX; a++) mem[a] = '0;
  endtask

  // Sequential reference model over the whole image.
  task automatic build_expected();
    int ar [ML+1]; int x0 [ML+1]; int x1 [ML+1]; int y0 [ML+1]; int y1 [ML+1];
    int sx [ML+1]; int sy [ML+1];
    rec_t e;
    for (int l = 0; l <= ML; l++) begin
      ar[l] = 0; x0[l] = 31; x1[l] = 0; y0[l] = 31; y1[l] = 0; sx[l] = 0; sy[l] = 0;
    end
    exp_ovf = 1'b0;
    for (int a = 0; a < PIX; a++) begin
      int q, r, c;
      q = int'(mem[a]); r = a / 32; c = a % 32;
      if (q > ML) exp_ovf = 1'b1;
      else if (q != 0) begin
        ar[q]++;
        if (c < x0[q]) x0[q] = c;
        if (c > x1[q]) x1[q] = c;
        if (r < y0[q]) y0[q] = r;
        if (r > y1[q]) y1[q] = r;
        sx[q] += c; sy[q] += r;
      end
    end
    for (int l = 1; l <= ML; l++) begin
      if (ar[l] != 0) begin
        e = '{l, ar[l], x0[l], x1[l], y0[l], y1[l], 0, 0};
`ifdef CLE_STATS_CENTROID_EN
        e.sx = sx[l]; e.sy = sy[l];
`endif
        exp_q.push_back(e);
      end
    end
  endtask

  // mode 0: ready always high; mode 1: ready low 50 valid cycles, then toggling.
  task automatic run(input int mode, output int done_cyc);
    int n, stall; bit holding, fin;
    rec_t held, cur, e;
    logic [AW-1:0] a_prev;
    build_expected();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    n = 1; stall = 0; holding = 0; fin = 0; done_cyc = -1; a_prev = '0;
    held = '{0, 0, 0, 0, 0, 0, 0, 0};
    while (!fin && n < 4000) begin
      if (res_valid) begin
        cur = '{int'(res_label), int'(res_area), int'(res_xmin), int'(res_xmax),
                int'(res_ymin), int'(res_ymax), int'(res_sum_x), int'(res_sum_y)};
        if (holding) begin
          check("hold_label", 32'(cur.label), 32'(held.label));
          check("hold_area",  32'(cur.area),  32'(held.area));
          check("hold_box",   32'({cur.xmin[4:0], cur.xmax[4:0], cur.ymin[4:0], cur.ymax[4:0]}),
                              32'({held.xmin[4:0], held.xmax[4:0], held.ymin[4:0], held.ymax[4:0]}));
          check("hold_sums",  32'({cur.sx[14:0], cur.sy[14:0]}), 32'({held.sx[14:0], held.sy[14:0]}));
          check("sram_a_frozen", 32'(sram_a), 32'(a_prev));
        end
        if (mode == 0) res_ready = 1'b1;
        else           res_ready = (stall >= 50) && (stall % 2 == 1);
        stall++;
        if (res_ready) begin
          if (exp_q.size() == 0) check("unexpected_record", 32'(cur.label), 0);
          else begin
            e = exp_q.pop_front();
            check("rec_label", 32'(cur.label), 32'(e.label));
            check("rec_area",  32'(cur.area),  32'(e.area));
            check("rec_xmin",  32'(cur.xmin),  32'(e.xmin));
            check("rec_xmax",  32'(cur.xmax),  32'(e.xmax));
            check("rec_ymin",  32'(cur.ymin),  32'(e.ymin));
            check("rec_ymax",  32'(cur.ymax),  32'(e.ymax));
            check("rec_sum_x", 32'(cur.sx),    32'(e.sx));
            check("rec_sum_y", 32'(cur.sy),    32'(e.sy));
          end
          holding = 0;
        end else begin
          holding = 1; held = cur; a_prev = sram_a;
        end
      end else begin
        res_ready = (mode == 0);
      end
      if (done) begin
        done_cyc = n; fin = 1;
        check("busy_at_done", 32'(busy), 1);
      end else begin
        @(negedge clk); n++;
      end
    end
    if (!fin) check("done_timeout", 0, 1);
    check("ovf_at_done", 32'(ovf), 32'(exp_ovf));
    check("records_left", 32'(exp_q.size()), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("busy_cleared", 32'(busy), 0);
    res_ready = 1'b0;
  endtask

  initial begin
    int dc;
    reset = 1'b1; start = 1'b0; res_ready = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_sram_a", 32'(sram_a), 0);
    check("rst_area", 32'(res_area), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: empty image, exact run length
    run(0, dc);
    check("empty_done_cycles", 32'(dc), 1058);

    // 2: rectangular label-3 block
    clear_mem();
    for (int r = 4; r <= 6; r++)
      for (int c = 10; c <= 13; c++) mem[r*32 + c] = 8'd3;
    run(0, dc);

    // 3: corner pixels, ascending label order
    clear_mem();
    mem[0] = 8'd1; mem[1023] = 8'd2; mem[31] = 8'd5;
    run(0, dc);

    // 4: out-of-range label flags overflow
    clear_mem();
    mem[100] = 8'd20; mem[101] = 8'd1;
    run(0, dc);

    // 5: backpressure with two labels
    clear_mem();
    for (int a = 200; a < 260; a++) mem[a] = 8'd7;
    mem[5] = 8'd9; mem[900] = 8'd9; mem[901] = 8'd9;
    run(1, dc);

    // 6: reset during scan, then a clean second run
    clear_mem();
    for (int a = 0; a < 600; a++) mem[a] = 8'd4;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 2000 && sram_a != 10'd500; k++) @(negedge clk);
    check("reach_addr_500", 32'(sram_a), 500);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(res_valid), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_sram_a", 32'(sram_a), 0);
    @(negedge clk); reset = 1'b0;
    clear_mem();
    for (int a = 64; a < 70; a++) mem[a] = 8'd4;
    mem[1000] = 8'd16;
    run(0, dc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
